sram_mem_controller: RTL and testbench

//  Sits between the pipeline MEM stage and the data SRAM. Accepts one read/write per request,

---
 rtl/sram_mem_controller_pkg.sv | 27 ++
 rtl/sram_mem_controller_if.sv | 29 ++
 rtl/sram_mem_controller_wait_counter.sv | 26 ++
 rtl/sram_mem_controller.sv | 155 +++++++++++++++
 tb/tb_sram_mem_controller.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/sram_mem_controller_pkg.sv
// Shared types and helpers for the SRAM memory controller: FSM state
// encoding, default window/latency parameters and the address window check.
package sram_mem_controller_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int DEFAULT_WAIT_CYCLES = 5;
  localparam int DEFAULT_BASE_ADDR   = 1024;
  localparam int DEFAULT_MEM_WORDS   = 64;

  // True when the byte address falls inside [base, base + 4*words); the two
  // byte-select bits are masked so only the word address takes part.
  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] words);
    logic [31:0] a_word;
    logic [31:0] b_word;
    a_word = addr & ~32'd3;
    b_word = base & ~32'd3;
    return (a_word >= b_word) && ((a_word - b_word) < (words << 2));
  endfunction

endpackage

// File: rtl/sram_mem_controller_if.sv
// Bundles the MEM-stage request/response signals and the SRAM pins.
// The slave modport is the controller's view; master is pipeline + SRAM.
interface sram_mem_controller_if;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        freeze;
  logic        addr_error;
  logic        sram_w_en;
  logic        sram_r_en;
  logic [31:0] sram_address;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data;

  modport slave (
    input  mem_r_en, mem_w_en, address, write_data, sram_read_data,
    output read_data, ready, freeze, addr_error,
           sram_w_en, sram_r_en, sram_address, sram_write_data
  );

  modport master (
    output mem_r_en, mem_w_en, address, write_data, sram_read_data,
    input  read_data, ready, freeze, addr_error,
           sram_w_en, sram_r_en, sram_address, sram_write_data
  );
endinterface

// File: rtl/sram_mem_controller_wait_counter.sv
// Wait-state counter for sram_mem_controller: counts cycles spent in an
// SRAM access and flags the last one (count == WAIT_CYCLES-1).
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);
  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Clear has priority so every access starts counting from zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal = (count == CNT_W'(WAIT_CYCLES - 1));
endmodule

// File: rtl/sram_mem_controller.sv
// SRAM memory controller between the pipeline MEM stage and the data SRAM.
// Holds SRAM enables/address/data for WAIT_CYCLES cycles per access,
// registers load data, freezes the pipeline until done and flags accesses
// outside the SRAM window.
// Optional feature: define SRAM_MEM_CONTROLLER_READ_CACHE_EN for a
// one-entry read cache that lets repeated reads of a word skip the SRAM.
module sram_mem_controller
  import sram_mem_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int MEM_WORDS   = DEFAULT_MEM_WORDS
) (
  input logic                  clk,
  input logic                  rst,
  sram_mem_controller_if.slave bus
);

  state_t      state;
  state_t      state_next;
  logic        req;
  logic        in_window;
  logic        cache_hit;
  logic        start_access;
  logic        start_error;
  logic        start_hit;
  logic        access_last;
  logic        cnt_terminal;
  logic [31:0] lat_addr;
  logic [31:0] lat_data;
  logic        lat_write;
  logic [31:0] read_data_q;
  logic        addr_error_q;
  logic [31:0] cache_rdata;

  assign req       = bus.mem_r_en | bus.mem_w_en;
  assign in_window = addr_in_window(bus.address, 32'(BASE_ADDR), 32'(MEM_WORDS));

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != ACCESS),
    .enable  (state == ACCESS),
    .terminal(cnt_terminal)
  );

  assign access_last = (state == ACCESS) && cnt_terminal;

`ifdef SRAM_MEM_CONTROLLER_READ_CACHE_EN
  logic        cache_valid;
  logic [29:0] cache_word;
  logic [31:0] cache_data;

  assign cache_hit   = bus.mem_r_en && !bus.mem_w_en && cache_valid &&
                       (cache_word == bus.address[31:2]);
  assign cache_rdata = cache_data;

  // Completed reads fill the entry; completed writes to the cached word keep it coherent.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid <= 1'b0;
      cache_word  <= '0;
      cache_data  <= '0;
    end else if (access_last) begin
      if (!lat_write) begin
        cache_valid <= 1'b1;
        cache_word  <= lat_addr[31:2];
        cache_data  <= bus.sram_read_data;
      end else if (cache_valid && (cache_word == lat_addr[31:2])) begin
        cache_data  <= lat_data;
      end
    end
  end
`else
  assign cache_hit   = 1'b0;
  assign cache_rdata = 32'd0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; out-of-window requests and cache hits skip ACCESS.
  always_comb begin
    state_next   = state;
    start_access = 1'b0;
    start_error  = 1'b0;
    start_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (!in_window) begin
            start_error = 1'b1;
            state_next  = DONE;
          end else if (cache_hit) begin
            start_hit   = 1'b1;
            state_next  = DONE;
          end else begin
            start_access = 1'b1;
            state_next   = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt_terminal) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch and response registers; a write (even with r_en) leaves read_data alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr     <= '0;
      lat_data     <= '0;
      lat_write    <= 1'b0;
      read_data_q  <= '0;
      addr_error_q <= 1'b0;
    end else begin
      addr_error_q <= start_error;
      if (start_access) begin
        lat_addr  <= bus.address;
        lat_data  <= bus.write_data;
        lat_write <= bus.mem_w_en;
      end
      if (start_error) begin
        read_data_q <= '0;
      end else if (start_hit) begin
        read_data_q <= cache_rdata;
      end else if (access_last && !lat_write) begin
        read_data_q <= bus.sram_read_data;
      end
    end
  end

  assign bus.read_data       = read_data_q;
  assign bus.addr_error      = addr_error_q;
  assign bus.ready           = (state == DONE);
  assign bus.freeze          = req && (state != DONE);
  assign bus.sram_w_en       = (state == ACCESS) && lat_write;
  assign bus.sram_r_en       = (state == ACCESS) && !lat_write;
  assign bus.sram_address    = (state == ACCESS) ? lat_addr : 32'd0;
  assign bus.sram_write_data = (state == ACCESS) ? lat_data : 32'd0;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed testbench for sram_mem_controller with a behavioural 64-word SRAM.
// Expected values are hand-computed for WAIT_CYCLES=5, BASE_ADDR=1024.
module tb_sram_mem_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] sram_mem [0:63];

  sram_mem_controller_if bus ();

  sram_mem_controller #(
    .WAIT_CYCLES(5),
    .BASE_ADDR  (1024),
    .MEM_WORDS  (64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Behavioural SRAM: synchronous write, combinational read while R_EN is high.
  always @(posedge clk) begin
    if (bus.sram_w_en) sram_mem[6'((bus.sram_address - 32'd1024) >> 2)] <= bus.sram_write_data;
  end
  assign bus.sram_read_data = bus.sram_r_en ? sram_mem[6'((bus.sram_address - 32'd1024) >> 2)] : 32'd0;

  // Drives one request from the next negedge until ready, counting cycles in which
  // freeze and the SRAM enables are high; ready cycle is -1 on timeout.
  task automatic do_access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                           output int rdy_cyc, output int wen_cnt, output int ren_cnt,
                           output int frz_cnt, output logic [31:0] rdata, output logic aerr,
                           output logic [31:0] seen_addr, output logic [31:0] seen_wdata);
    @(negedge clk);
    bus.mem_r_en = r; bus.mem_w_en = w; bus.address = a; bus.write_data = d;
    #1;
    rdy_cyc = -1; wen_cnt = 0; ren_cnt = 0; frz_cnt = 0;
    rdata = 'x; aerr = 1'bx; seen_addr = 0; seen_wdata = 0;
    if (bus.freeze) frz_cnt++;
    if (bus.sram_w_en) wen_cnt++;
    if (bus.sram_r_en) ren_cnt++;
    for (int i = 1; i <= 20 && rdy_cyc < 0; i++) begin
      @(negedge clk);
      if (bus.freeze) frz_cnt++;
      if (bus.sram_w_en) begin wen_cnt++; seen_addr = bus.sram_address; seen_wdata = bus.sram_write_data; end
      if (bus.sram_r_en) begin ren_cnt++; seen_addr = bus.sram_address; end
      if (bus.ready) begin rdy_cyc = i; rdata = bus.read_data; aerr = bus.addr_error; end
    end
    bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", bus.ready); end
    checks++; if (bus.read_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_read_data: got %h expected 0", bus.read_data); end
    checks++; if (bus.addr_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_addr_error: got %b expected 0", bus.addr_error); end
    checks++; if (bus.freeze !== 1'b0) begin errors++; $display("[TB] FAIL reset_freeze: got %b expected 0", bus.freeze); end
    checks++; if ({bus.sram_w_en, bus.sram_r_en, bus.sram_address} !== 34'd0) begin
      errors++; $display("[TB] FAIL reset_sram: got w=%b r=%b a=%h expected all 0", bus.sram_w_en, bus.sram_r_en, bus.sram_address);
    end
    rst = 1'b0;
  endtask

  task automatic test_write();
    int rc, wc, rdc, fc; logic [31:0] rd, sa, sw; logic ae;
    do_access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, rc, wc, rdc, fc, rd, ae, sa, sw);
    checks++; if (rc !== 6) begin errors++; $display("[TB] FAIL write_ready_cycle: got %0d expected 6", rc); end
    checks++; if (wc !== 5) begin errors++; $display("[TB] FAIL write_wen_cycles: got %0d expected 5", wc); end
    checks++; if (rdc !== 0) begin errors++; $display("[TB] FAIL write_ren_cycles: got %0d expected 0", rdc); end
    checks++; if (fc !== 6) begin errors++; $display("[TB] FAIL write_freeze_cycles: got %0d expected 6", fc); end
    checks++; if (ae !== 1'b0) begin errors++; $display("[TB] FAIL write_addr_error: got %b expected 0", ae); end
    checks++; if (sa !== 32'd1028) begin errors++; $display("[TB] FAIL write_sram_address: got %0d expected 1028", sa); end
    checks++; if (sw !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL write_sram_data: got %h expected deadbeef", sw); end
  endtask

  task automatic test_read();
    int rc, wc, rdc, fc; logic [31:0] rd, sa, sw; logic ae;
    do_access(1'b1, 1'b0, 32'd1028, 32'd0, rc, wc, rdc, fc, rd, ae, sa, sw);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL read_data: got %h expected deadbeef", rd); end
    checks++; if (rc !== 6) begin errors++; $display("[TB] FAIL read_ready_cycle: got %0d expected 6", rc); end
    checks++; if (fc !== 6) begin errors++; $display("[TB] FAIL read_freeze_cycles: got %0d expected 6", fc); end
    checks++; if (rdc !== 5 || wc !== 0) begin errors++; $display("[TB] FAIL read_enables: got ren=%0d wen=%0d expected 5/0", rdc, wc); end
  endtask

  task automatic test_read_write_both();
    int rc, wc, rdc, fc; logic [31:0] rd, sa, sw; logic ae;
    do_access(1'b1, 1'b0, 32'd1028, 32'd0, rc, wc, rdc, fc, rd, ae, sa, sw);
    do_access(1'b1, 1'b1, 32'd1032, 32'h5, rc, wc, rdc, fc, rd, ae, sa, sw);
    checks++; if (wc !== 5 || rdc !== 0) begin errors++; $display("[TB] FAIL both_enables: got wen=%0d ren=%0d expected 5/0", wc, rdc); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL both_read_data_kept: got %h expected deadbeef", rd); end
    do_access(1'b1, 1'b0, 32'd1032, 32'd0, rc, wc, rdc, fc, rd, ae, sa, sw);
    checks++; if (rd !== 32'h5) begin errors++; $display("[TB] FAIL both_readback: got %h expected 5", rd); end
  endtask

  task automatic test_out_of_window();
    int rc, wc, rdc, fc; logic [31:0] rd, sa, sw; logic ae;
    logic [31:0] bad_addrs [2] = '{32'd512, 32'd1280};
    foreach (bad_addrs[k]) begin
      do_access(1'b1, 1'b0, bad_addrs[k], 32'd0, rc, wc, rdc, fc, rd, ae, sa, sw);
      checks++; if (rc !== 1) begin errors++; $display("[TB] FAIL oow_ready_cycle@%0d: got %0d expected 1", bad_addrs[k], rc); end
      checks++; if (ae !== 1'b1) begin errors++; $display("[TB] FAIL oow_addr_error@%0d: got %b expected 1", bad_addrs[k], ae); end
      checks++; if (rd !== 32'd0) begin errors++; $display("[TB] FAIL oow_read_data@%0d: got %h expected 0", bad_addrs[k], rd); end
      checks++; if (wc !== 0 || rdc !== 0) begin errors++; $display("[TB] FAIL oow_enables@%0d: got wen=%0d ren=%0d expected 0/0", bad_addrs[k], wc, rdc); end
      checks++; if (fc !== 1) begin errors++; $display("[TB] FAIL oow_freeze@%0d: got %0d expected 1", bad_addrs[k], fc); end
    end
    do_access(1'b1, 1'b0, 32'd1276, 32'd0, rc, wc, rdc, fc, rd, ae, sa, sw);
    checks++; if (ae !== 1'b0 || rc !== 6) begin errors++; $display("[TB] FAIL last_word_in_window: got err=%b ready=%0d expected 0/6", ae, rc); end
  endtask

  task automatic test_back_to_back();
    int rc;
    @(negedge clk);
    bus.mem_w_en = 1'b1; bus.mem_r_en = 1'b0; bus.address = 32'd1044; bus.write_data = 32'hA5;
    rc = -1;
    for (int i = 1; i <= 20 && rc < 0; i++) begin @(negedge clk); if (bus.ready) rc = i; end
    checks++; if (rc !== 6) begin errors++; $display("[TB] FAIL b2b_write_ready: got %0d expected 6", rc); end
    bus.mem_w_en = 1'b0; bus.mem_r_en = 1'b1;
    rc = -1;
    for (int i = 1; i <= 20 && rc < 0; i++) begin @(negedge clk); if (bus.ready) rc = i; end
    checks++; if (rc !== 7) begin errors++; $display("[TB] FAIL b2b_read_ready: got %0d expected 7", rc); end
    checks++; if (bus.read_data !== 32'hA5) begin errors++; $display("[TB] FAIL b2b_read_data: got %h expected a5", bus.read_data); end
    bus.mem_r_en = 1'b0;
  endtask

  task automatic test_cache();
    int rc, wc, rdc, fc; logic [31:0] rd, sa, sw; logic ae;
    do_access(1'b1, 1'b0, 32'd1028, 32'd0, rc, wc, rdc, fc, rd, ae, sa, sw);
    checks++; if (rc !== 6) begin errors++; $display("[TB] FAIL cache_first_read_ready: got %0d expected 6", rc); end
    do_access(1'b1, 1'b0, 32'd1028, 32'd0, rc, wc, rdc, fc, rd, ae, sa, sw);
`ifdef SRAM_MEM_CONTROLLER_READ_CACHE_EN
    checks++; if (rc !== 1 || rdc !== 0) begin errors++; $display("[TB] FAIL cache_hit_timing: got ready=%0d ren=%0d expected 1/0", rc, rdc); end
`else
    checks++; if (rc !== 6 || rdc !== 5) begin errors++; $display("[TB] FAIL nocache_second_read: got ready=%0d ren=%0d expected 6/5", rc, rdc); end
`endif
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL cache_second_read_data: got %h expected deadbeef", rd); end
    do_access(1'b0, 1'b1, 32'd1028, 32'hCAFEF00D, rc, wc, rdc, fc, rd, ae, sa, sw);
    do_access(1'b1, 1'b0, 32'd1028, 32'd0, rc, wc, rdc, fc, rd, ae, sa, sw);
`ifdef SRAM_MEM_CONTROLLER_READ_CACHE_EN
    checks++; if (rc !== 1) begin errors++; $display("[TB] FAIL cache_updated_hit_ready: got %0d expected 1", rc); end
`else
    checks++; if (rc !== 6) begin errors++; $display("[TB] FAIL nocache_reread_ready: got %0d expected 6", rc); end
`endif
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL cache_updated_data: got %h expected cafef00d", rd); end
  endtask

  task automatic test_reset_mid_access();
    int rc, wc, rdc, fc; logic [31:0] rd, sa, sw; logic ae;
    @(negedge clk);
    bus.mem_w_en = 1'b1; bus.mem_r_en = 1'b0; bus.address = 32'd1036; bus.write_data = 32'h77;
    @(negedge clk);
    checks++; if (bus.sram_w_en !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_wen: got %b expected 1", bus.sram_w_en); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({bus.sram_w_en, bus.sram_r_en, bus.sram_address, bus.sram_write_data} !== 66'd0) begin
      errors++; $display("[TB] FAIL rst_sram_outputs: got w=%b r=%b a=%h d=%h expected all 0",
                         bus.sram_w_en, bus.sram_r_en, bus.sram_address, bus.sram_write_data);
    end
    checks++; if ({bus.ready, bus.addr_error, bus.read_data} !== 34'd0) begin
      errors++; $display("[TB] FAIL rst_resp_outputs: got rdy=%b err=%b rd=%h expected all 0", bus.ready, bus.addr_error, bus.read_data);
    end
    checks++; if (bus.freeze !== 1'b1) begin errors++; $display("[TB] FAIL rst_freeze_follows_req: got %b expected 1", bus.freeze); end
    rst = 1'b0; bus.mem_w_en = 1'b0;
    do_access(1'b1, 1'b0, 32'd1028, 32'd0, rc, wc, rdc, fc, rd, ae, sa, sw);
    checks++; if (rc !== 6 || rd !== 32'hCAFEF00D) begin
      errors++; $display("[TB] FAIL rst_recovery_read: got ready=%0d data=%h expected 6/cafef00d", rc, rd);
    end
  endtask

  // Runs every scenario in order; later tests rely on memory contents left by earlier ones.
  initial begin
    for (int i = 0; i < 64; i++) sram_mem[i] = 32'd0;
    bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0; bus.address = 32'd0; bus.write_data = 32'd0;
    test_reset();
    test_write();
    test_read();
    test_read_write_both();
    test_out_of_window();
    test_back_to_back();
    test_cache();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
